amplitude_ramp_scaler: RTL and testbench

AMPLITUDE_RAMP_SCALER -- requirements
Module: amplitude_ramp_scaler

---
 rtl/amplitude_ramp_scaler_if.sv | 34 +++
 rtl/amplitude_ramp_scaler.sv | 117 +++++++++++
 tb/tb_amplitude_ramp_scaler.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/amplitude_ramp_scaler_if.sv
// Sample stream bundle for amplitude_ramp_scaler: valid/ready input stream and
// valid/ready output stream sharing one sample width.
interface amplitude_ramp_scaler_if #(
  parameter int unsigned DATA_BITS = 16
) ();

  logic [DATA_BITS-1:0] din;
  logic                 in_valid;
  logic                 in_ready;
  logic [DATA_BITS-1:0] dout;
  logic                 out_valid;
  logic                 out_ready;

  // Upstream source plus downstream sink, seen from outside the scaler
  modport master (
    output din,
    output in_valid,
    input  in_ready,
    input  dout,
    input  out_valid,
    output out_ready
  );

  // The scaler itself
  modport slave (
    input  din,
    input  in_valid,
    output in_ready,
    output dout,
    output out_valid,
    input  out_ready
  );

endinterface

// File: rtl/amplitude_ramp_scaler.sv
// Offset-binary sample scaler whose gain ramps one LSB per RAMP_SAMPLES accepted
// samples toward amp_target; one-cycle registered pipeline with valid/ready flow.
module amplitude_ramp_scaler #(
  parameter int unsigned DATA_BITS    = 16,
  parameter int unsigned AMP_BITS     = 8,
  parameter int unsigned RAMP_SAMPLES = 64,
  parameter int unsigned RESET_GAIN   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  amplitude_ramp_scaler_if.slave bus,
  input  logic [AMP_BITS-1:0]   amp_target,
  output logic [AMP_BITS-1:0]   gain,
  output logic                  ramping
);

  localparam int unsigned PROD_BITS = DATA_BITS + AMP_BITS + 1;
  localparam int unsigned CNT_BITS  = (RAMP_SAMPLES > 1) ? $clog2(RAMP_SAMPLES) : 1;

  localparam logic [CNT_BITS-1:0]  CNT_LAST = CNT_BITS'(RAMP_SAMPLES - 1);
  localparam logic [DATA_BITS-1:0] MIDPOINT = {1'b1, {(DATA_BITS-1){1'b0}}};
  localparam logic [AMP_BITS-1:0]  GAIN_RST = AMP_BITS'(RESET_GAIN);

  typedef enum logic [1:0] {
    HOLD      = 2'd0,
    RAMP_UP   = 2'd1,
    RAMP_DOWN = 2'd2
  } state_t;

  state_t                       state;
  state_t                       state_nxt;
  logic                         step_en;
  logic [CNT_BITS-1:0]          step_cnt;
  logic                         accept;
  logic [DATA_BITS-1:0]         s_off;
  logic signed [PROD_BITS-1:0]  s_ext;
  logic signed [PROD_BITS-1:0]  g_ext;
  logic signed [PROD_BITS-1:0]  product;
  logic [DATA_BITS-1:0]         scaled;

  // Flow control: a free or draining output slot lets a new sample in
  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  // Flipping the MSB turns offset-binary into two's complement and back
  assign s_off   = bus.din ^ MIDPOINT;
  assign s_ext   = {{(AMP_BITS+1){s_off[DATA_BITS-1]}}, s_off};
  assign g_ext   = {{(DATA_BITS+1){1'b0}}, gain};
  assign product = s_ext * g_ext;
  // Arithmetic shift floors; |gain| < 1.0 so the result always fits DATA_BITS
  assign scaled  = DATA_BITS'(product >>> AMP_BITS) ^ MIDPOINT;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= HOLD;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: direction from the registered gain against the live target
  always_comb begin
    state_nxt = HOLD;
    if (gain < amp_target) begin
      state_nxt = RAMP_UP;
    end else if (gain > amp_target) begin
      state_nxt = RAMP_DOWN;
    end
  end

  // State-derived outputs
  always_comb begin
    ramping = 1'b0;
    step_en = 1'b0;
    if (state != HOLD) begin
      ramping = 1'b1;
      step_en = accept;
    end
  end

  // Step counter and gain; gain only moves on accepted samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_cnt <= '0;
      gain     <= GAIN_RST;
    end else if (state_nxt == HOLD) begin
      step_cnt <= '0;
    end else if (step_en) begin
      if (step_cnt == CNT_LAST) begin
        step_cnt <= '0;
        // Never steps past target: state_nxt is HOLD once gain reaches it
        if (state_nxt == RAMP_UP) begin
          gain <= gain + AMP_BITS'(1);
        end else begin
          gain <= gain - AMP_BITS'(1);
        end
      end else begin
        step_cnt <= step_cnt + CNT_BITS'(1);
      end
    end
  end

  // Output register: load on accept, drop valid once drained
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.dout      <= MIDPOINT;
      bus.out_valid <= 1'b0;
    end else if (accept) begin
      bus.dout      <= scaled;
      bus.out_valid <= 1'b1;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_amplitude_ramp_scaler.sv
// Directed bench for amplitude_ramp_scaler: scaling table on a unity-half-gain
// instance, ramp/reversal/back-pressure/reset sequences on two instances.
module tb_amplitude_ramp_scaler;

  localparam int unsigned DATA_BITS = 16;
  localparam int unsigned AMP_BITS  = 8;

  logic clk;
  logic rst;
  logic [AMP_BITS-1:0] target_a;
  logic [AMP_BITS-1:0] target_b;
  logic [AMP_BITS-1:0] gain_a;
  logic [AMP_BITS-1:0] gain_b;
  logic ramping_a;
  logic ramping_b;

  int n_checks;
  int n_fail;

  amplitude_ramp_scaler_if #(.DATA_BITS(DATA_BITS)) bus_a ();
  amplitude_ramp_scaler_if #(.DATA_BITS(DATA_BITS)) bus_b ();

  amplitude_ramp_scaler #(
    .DATA_BITS(DATA_BITS), .AMP_BITS(AMP_BITS), .RAMP_SAMPLES(4), .RESET_GAIN(128)
  ) u_dut_a (
    .clk(clk), .rst(rst), .bus(bus_a),
    .amp_target(target_a), .gain(gain_a), .ramping(ramping_a)
  );

  amplitude_ramp_scaler #(
    .DATA_BITS(DATA_BITS), .AMP_BITS(AMP_BITS), .RAMP_SAMPLES(4), .RESET_GAIN(0)
  ) u_dut_b (
    .clk(clk), .rst(rst), .bus(bus_b),
    .amp_target(target_b), .gain(gain_b), .ramping(ramping_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] din;
    logic [15:0] exp_dout;
  } vec_t;

  vec_t vecs[10];
  logic [15:0] ramp_dout[3];
  logic [15:0] bp_din[6];
  logic [15:0] bp_dout[6];
  logic [7:0]  bp_gain[6];
  logic [7:0]  rev_gain[6];

  initial begin
    // Gain 128 (x0.5): floor((din-0x8000)*128/256)+0x8000
    vecs[0] = '{16'hFFFF, 16'hBFFF};
    vecs[1] = '{16'h0000, 16'h4000};
    vecs[2] = '{16'h8000, 16'h8000};
    vecs[3] = '{16'h8001, 16'h8000};
    vecs[4] = '{16'h7FFF, 16'h7FFF};
    vecs[5] = '{16'hC000, 16'hA000};
    vecs[6] = '{16'h1234, 16'h491A};
    vecs[7] = '{16'h8003, 16'h8001};
    vecs[8] = '{16'h7FFD, 16'h7FFE};
    vecs[9] = '{16'h4000, 16'h6000};
    // din 0xFFFF at gains 0,1,2
    ramp_dout = '{16'h8000, 16'h807F, 16'h80FF};
    // Back-pressure stream on A: gain 128 for four acceptances, then 129
    bp_din  = '{16'h9000, 16'hA000, 16'h7000, 16'h6000, 16'h8100, 16'h7F00};
    bp_dout = '{16'h8800, 16'h9000, 16'h7800, 16'h7000, 16'h8081, 16'h7F7F};
    bp_gain = '{8'd128, 8'd128, 8'd128, 8'd129, 8'd129, 8'd129};
    rev_gain = '{8'd2, 8'd1, 8'd1, 8'd1, 8'd1, 8'd0};

    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    target_a = 8'd128;
    target_b = 8'd3;
    bus_a.din = '0; bus_a.in_valid = 1'b0; bus_a.out_ready = 1'b1;
    bus_b.din = '0; bus_b.in_valid = 1'b0; bus_b.out_ready = 1'b1;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_dout_a", 32'(bus_a.dout), 32'h8000);
    check("rst_valid_a", 32'(bus_a.out_valid), 32'd0);
    check("rst_gain_a", 32'(gain_a), 32'd128);
    check("rst_gain_b", 32'(gain_b), 32'd0);
    check("rst_ramping_b", 32'(ramping_b), 32'd0);
    check("rst_in_ready_a", 32'(bus_a.in_ready), 32'd1);
    rst = 1'b0;

    // Scaling table on A, back-to-back samples
    @(negedge clk);
    bus_a.din = vecs[0].din;
    bus_a.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("scale_dout[%0d]", i), 32'(bus_a.dout), 32'(vecs[i].exp_dout));
      check($sformatf("scale_valid[%0d]", i), 32'(bus_a.out_valid), 32'd1);
      if (i < 9) bus_a.din = vecs[i+1].din;
      else bus_a.in_valid = 1'b0;
    end
    @(negedge clk);
    check("scale_valid_drop", 32'(bus_a.out_valid), 32'd0);
    check("scale_hold_gain", 32'(gain_a), 32'd128);

    // Ramp-up on B: 0 -> 3 over 12 acceptances
    check("ramp_start_ramping", 32'(ramping_b), 32'd1);
    check("ramp_start_gain", 32'(gain_b), 32'd0);
    bus_b.din = 16'hFFFF;
    bus_b.in_valid = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      check($sformatf("ramp_gain[%0d]", k), 32'(gain_b), 32'(k / 4));
      check($sformatf("ramp_dout[%0d]", k), 32'(bus_b.dout), 32'(ramp_dout[(k-1)/4]));
    end
    bus_b.in_valid = 1'b0;
    @(negedge clk);
    check("ramp_done_ramping", 32'(ramping_b), 32'd0);
    check("ramp_done_gain", 32'(gain_b), 32'd3);

    // Reversal: reset, ramp to gain 2 / counter 2, then retarget to 0
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rev_rst_gain", 32'(gain_b), 32'd0);
    @(negedge clk);
    bus_b.in_valid = 1'b1;
    repeat (10) @(negedge clk);
    check("rev_pre_gain", 32'(gain_b), 32'd2);
    bus_b.in_valid = 1'b0;
    target_b = 8'd0;
    @(negedge clk);
    check("rev_ramping", 32'(ramping_b), 32'd1);
    bus_b.in_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("rev_gain[%0d]", k + 1), 32'(gain_b), 32'(rev_gain[k]));
    end
    bus_b.in_valid = 1'b0;
    @(negedge clk);
    check("rev_done_ramping", 32'(ramping_b), 32'd0);

    // Back-pressure on A during a ramp 128 -> 130
    target_a = 8'd130;
    @(negedge clk);
    check("bp_ramping", 32'(ramping_a), 32'd1);
    bus_a.din = bp_din[0];
    bus_a.in_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("bp_dout[%0d]", k), 32'(bus_a.dout), 32'(bp_dout[k]));
      check($sformatf("bp_gain[%0d]", k), 32'(gain_a), 32'(bp_gain[k]));
      if (k < 5) bus_a.din = bp_din[k+1];
      else bus_a.in_valid = 1'b0;
      if (k == 1) begin
        bus_a.out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          check($sformatf("bp_stall_in_ready[%0d]", c), 32'(bus_a.in_ready), 32'd0);
          check($sformatf("bp_stall_dout[%0d]", c), 32'(bus_a.dout), 32'(bp_dout[1]));
          check($sformatf("bp_stall_valid[%0d]", c), 32'(bus_a.out_valid), 32'd1);
          check($sformatf("bp_stall_gain[%0d]", c), 32'(gain_a), 32'd128);
        end
        bus_a.out_ready = 1'b1;
      end
    end

    // Mid-ramp asynchronous reset on B (RAMP_UP, out_valid high)
    target_b = 8'd3;
    @(negedge clk);
    bus_b.din = 16'hFFFF;
    bus_b.in_valid = 1'b1;
    repeat (5) @(negedge clk);
    check("mid_pre_gain", 32'(gain_b), 32'd1);
    check("mid_pre_dout", 32'(bus_b.dout), 32'h807F);
    check("mid_pre_valid", 32'(bus_b.out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_dout_b", 32'(bus_b.dout), 32'h8000);
    check("mid_rst_valid_b", 32'(bus_b.out_valid), 32'd0);
    check("mid_rst_gain_b", 32'(gain_b), 32'd0);
    check("mid_rst_ramping_b", 32'(ramping_b), 32'd0);
    check("mid_rst_in_ready_b", 32'(bus_b.in_ready), 32'd1);
    check("mid_rst_gain_a", 32'(gain_a), 32'd128);
    check("mid_rst_ramping_a", 32'(ramping_a), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    check("post_rst_valid_b", 32'(bus_b.out_valid), 32'd0);
    bus_a.din = 16'h9000;
    bus_a.in_valid = 1'b1;
    @(negedge clk);
    bus_a.in_valid = 1'b0;
    bus_b.in_valid = 1'b0;
    check("post_rst_dout_a", 32'(bus_a.dout), 32'h8800);
    check("post_rst_valid_a", 32'(bus_a.out_valid), 32'd1);
    check("post_rst_dout_b", 32'(bus_b.dout), 32'h8000);
    check("post_rst_gain_b", 32'(gain_b), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
